video_frame_gate: RTL and testbench

Front-end stage of the Ethernet video path. It takes 720p RGB888 video with DE/HS/VS timing on sys_clk, converts it to RGB565, and passes one of every (skip_n+1) frames to the UDP line buffer that follows. That buffer consumes out_vsync, out_hsync, out_de (its rgb_valid) and out_rgb. Syncs are always forwarded, so the downstream line counter stays aligned. Only pixel-valid and pixel data are gated, and gating changes only at frame boundaries.

---
 rtl/video_frame_gate.sv | 171 +++++++++++++++++
 tb/tb_video_frame_gate.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_gate.sv
// RGB888 -> RGB565 video front end that forwards syncs and passes one of every (skip_n+1) frames.
// Optional build macro FRAME_TAG_EN stamps frame_cnt and 16'hA5A5 into the first two active pixels.
module video_frame_gate #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned SKIP_W   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_de,
  input  logic [23:0]       in_rgb,
  input  logic              gate_en,
  input  logic [SKIP_W-1:0] skip_n,
  output logic              out_vsync,
  output logic              out_hsync,
  output logic              out_de,
  output logic [15:0]       out_rgb,
  output logic [15:0]       frame_cnt,
  output logic              frame_drop,
  output logic              line_err
);

  localparam int unsigned PixW  = 11;
  localparam int unsigned LineW = 10;
  localparam logic [PixW-1:0]  HActive = PixW'(H_ACTIVE);
  localparam logic [LineW-1:0] VActive = LineW'(V_ACTIVE);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPass = 2'd1;
  localparam logic [1:0] StSkip = 2'd2;

  // Stage 1: registered inputs plus edge detectors
  logic        vs_q, hs_q, de_q;
  logic [23:0] rgb_q;
  logic        fs_q;
  logic        de_end_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      de_q     <= 1'b0;
      rgb_q    <= 24'h000000;
      fs_q     <= 1'b0;
      de_end_q <= 1'b0;
    end else begin
      vs_q     <= in_vsync;
      hs_q     <= in_hsync;
      de_q     <= in_de;
      rgb_q    <= in_rgb;
      fs_q     <= in_vsync & ~vs_q;
      de_end_q <= de_q & ~in_de;
    end
  end

  // Frame gating state
  logic [1:0]        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              drop_d;

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    frame_cnt_d = frame_cnt_q;
    drop_d      = 1'b0;
    if (fs_q) begin
      if (!gate_en) begin
        state_d = StIdle;
      end else if (skip_cnt_q == '0) begin
        state_d     = StPass;
        skip_cnt_d  = skip_n;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        state_d    = StSkip;
        skip_cnt_d = skip_cnt_q - 1'b1;
        drop_d     = 1'b1;
      end
    end
  end

  // Geometry checking; counters only advance inside PASS frames
  logic              pass_now;
  logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [LineW-1:0]  line_cnt_q, line_cnt_d;
  logic [LineW-1:0]  line_eff;
  logic              err_q, err_d;

  assign pass_now = (state_q == StPass);

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    err_d      = err_q;
    // A DE end coinciding with the frame start still counts toward the closing frame
    line_eff   = line_cnt_q + LineW'(de_end_q & pass_now);

    if (de_end_q) begin
      if (pass_now && (pix_cnt_q != HActive)) begin
        err_d = 1'b1;
      end
      pix_cnt_d = '0;
    end else if (de_q && pass_now) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    if (fs_q) begin
      if (pass_now && (line_eff != VActive)) begin
        err_d = 1'b1;
      end
      line_cnt_d = '0;
    end else if (de_end_q && pass_now) begin
      line_cnt_d = line_cnt_q + 1'b1;
    end
  end

  // Stage 2 output datapath
  logic        de_d;
  logic [15:0] rgb_d;

  always_comb begin
    de_d  = de_q & (state_d == StPass);
    rgb_d = 16'h0000;
    if (de_d) begin
      rgb_d = {rgb_q[23:19], rgb_q[15:10], rgb_q[7:3]};
`ifdef FRAME_TAG_EN
      if (line_cnt_q == '0) begin
        if (pix_cnt_q == PixW'(0)) begin
          rgb_d = frame_cnt_q;
        end else if (pix_cnt_q == PixW'(1)) begin
          rgb_d = 16'hA5A5;
        end
      end
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      skip_cnt_q  <= '0;
      frame_cnt_q <= 16'h0000;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      err_q       <= 1'b0;
      out_vsync   <= 1'b0;
      out_hsync   <= 1'b0;
      out_de      <= 1'b0;
      out_rgb     <= 16'h0000;
      frame_drop  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      err_q       <= err_d;
      out_vsync   <= vs_q;
      out_hsync   <= hs_q;
      out_de      <= de_d;
      out_rgb     <= rgb_d;
      frame_drop  <= drop_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign line_err  = err_q;

endmodule

// File: tb/tb_video_frame_gate.sv
// Directed bench for video_frame_gate on a reduced 8x4 frame geometry.
// Every step compares the 2-cycle-delayed outputs against the inputs the bench drove.
module tb_video_frame_gate;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        in_vsync, in_hsync, in_de;
  logic [23:0] in_rgb;
  logic        gate_en;
  logic [3:0]  skip_n;
  logic        out_vsync, out_hsync, out_de;
  logic [15:0] out_rgb;
  logic [15:0] frame_cnt;
  logic        frame_drop;
  logic        line_err;

  video_frame_gate #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .SKIP_W  (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_vsync  (in_vsync),
    .in_hsync  (in_hsync),
    .in_de     (in_de),
    .in_rgb    (in_rgb),
    .gate_en   (gate_en),
    .skip_n    (skip_n),
    .out_vsync (out_vsync),
    .out_hsync (out_hsync),
    .out_de    (out_de),
    .out_rgb   (out_rgb),
    .frame_cnt (frame_cnt),
    .frame_drop(frame_drop),
    .line_err  (line_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Expectations for the outputs one step later
  logic        p_vs, p_hs, p_de;
  logic [15:0] p_rgb;
  logic        cur_pass;
  logic [15:0] exp_fcnt;
  logic        exp_err;
  logic        hs_last;
  int          de_seen, drop_seen, hs_rise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  task automatic step(input logic vs, input logic hs, input logic de, input logic [23:0] rgb,
                      input logic [15:0] e_rgb);
    in_vsync = vs;
    in_hsync = hs;
    in_de    = de;
    in_rgb   = rgb;
    @(posedge sys_clk);
    #1;
    chk("out_vsync", {31'd0, out_vsync}, {31'd0, p_vs});
    chk("out_hsync", {31'd0, out_hsync}, {31'd0, p_hs});
    chk("out_de", {31'd0, out_de}, {31'd0, p_de});
    chk("out_rgb", {16'd0, out_rgb}, {16'd0, p_rgb});
    if (out_de) de_seen++;
    if (frame_drop) drop_seen++;
    if (out_hsync && !hs_last) hs_rise++;
    hs_last = out_hsync;
    p_vs  = vs;
    p_hs  = hs;
    p_de  = de & cur_pass;
    p_rgb = (de && cur_pass) ? e_rgb : 16'h0000;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 24'h0, 16'h0);
  endtask

  // One frame: optional vsync pulse, then V lines; short_line gets H-1 pixels,
  // gate_en drops at the start of drop_line (-1 for neither).
  task automatic frame(input bit with_vs, input bit pass, input int short_line,
                       input int drop_line);
    logic [23:0] rgb;
    logic [15:0] e;
    logic        err_before;
    int          npix;
    cur_pass = pass;
    if (with_vs) begin
      if (pass) exp_fcnt = exp_fcnt + 16'd1;
      step(1'b1, 1'b0, 1'b0, 24'h0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 24'h0, 16'h0);
      repeat (3) idle_step();
    end
    for (int j = 0; j < int'(V); j++) begin
      if (j == drop_line) gate_en = 1'b0;
      step(1'b0, 1'b1, 1'b0, 24'h0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 24'h0, 16'h0);
      idle_step();
      idle_step();
      npix = (j == short_line) ? int'(H) - 1 : int'(H);
      for (int k = 0; k < npix; k++) begin
        if (k == 3) begin
          rgb = 24'hFF8040;
          e   = 16'hFC08;
        end else begin
          rgb = {8'(k * 29 + j), 8'(j * 53 + 7), 8'(k * 5 + j * 11)};
          e   = to565(rgb);
        end
`ifdef FRAME_TAG_EN
        if (j == 0 && k == 0) e = exp_fcnt;
        if (j == 0 && k == 1) e = 16'hA5A5;
`endif
        step(1'b0, 1'b0, 1'b1, rgb, e);
      end
      err_before = exp_err;
      idle_step();
      if (pass) chk("line_err_before", {31'd0, line_err}, {31'd0, err_before});
      if (pass && npix != int'(H)) exp_err = 1'b1;
      idle_step();
      if (pass) chk("line_err_after", {31'd0, line_err}, {31'd0, exp_err});
    end
  endtask

  int de0, drop0, hs0;
  bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    p_vs = 1'b0; p_hs = 1'b0; p_de = 1'b0; p_rgb = 16'h0;
    cur_pass = 1'b0; exp_fcnt = 16'h0; exp_err = 1'b0; hs_last = 1'b0;
    de_seen = 0; drop_seen = 0; hs_rise = 0;
    in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_rgb = 24'h0;
    gate_en = 1'b1; skip_n = 4'd0;

    sys_rst_n = 1'b0;
    in_vsync = 1'b1; in_hsync = 1'b1; in_de = 1'b1; in_rgb = 24'hFFFFFF;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_out_vsync", {31'd0, out_vsync}, 32'd0);
    chk("rst_out_hsync", {31'd0, out_hsync}, 32'd0);
    chk("rst_out_de", {31'd0, out_de}, 32'd0);
    chk("rst_out_rgb", {16'd0, out_rgb}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_frame_drop", {31'd0, frame_drop}, 32'd0);
    chk("rst_line_err", {31'd0, line_err}, 32'd0);
    in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_rgb = 24'h0;
    sys_rst_n = 1'b1;

    // Partial frame after reset is blocked, then two passed frames
    de0 = de_seen;
    frame(1'b0, 1'b0, -1, -1);
    chk("partial_frame_de", de_seen - de0, 32'd0);
    de0 = de_seen;
    frame(1'b1, 1'b1, -1, -1);
    chk("frame2_de", de_seen - de0, H * V);
    de0 = de_seen;
    frame(1'b1, 1'b1, -1, -1);
    chk("frame3_de", de_seen - de0, H * V);
    chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
    chk("line_err_clean", {31'd0, line_err}, 32'd0);

    // skip_n=2 from skip_cnt=0: pass, skip, skip, pass, skip, skip, pass
    skip_n = 4'd2;
    de0 = de_seen;
    drop0 = drop_seen;
    for (int f = 0; f < 7; f++) begin
      frame(1'b1, pat[f], -1, -1);
      chk("skip_seq_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fcnt});
    end
    chk("skip_seq_drops", drop_seen - drop0, 32'd4);
    chk("skip_seq_de", de_seen - de0, 3 * H * V);
    chk("frame_cnt_5", {16'd0, frame_cnt}, 32'd5);

    // Back to every frame: two leftover skips, then passes
    skip_n = 4'd0;
    frame(1'b1, 1'b0, -1, -1);
    frame(1'b1, 1'b0, -1, -1);
    frame(1'b1, 1'b1, -1, -1);
    chk("frame_cnt_6", {16'd0, frame_cnt}, 32'd6);

    // Short line 2 sets line_err, which stays set through a clean frame
    frame(1'b1, 1'b1, 2, -1);
    frame(1'b1, 1'b1, -1, -1);
    chk("line_err_sticky", {31'd0, line_err}, 32'd1);

    // gate_en drops mid-PASS: frame finishes, next frame fully blocked
    de0 = de_seen;
    frame(1'b1, 1'b1, -1, 1);
    chk("gate_drop_frame_de", de_seen - de0, H * V);
    de0 = de_seen;
    hs0 = hs_rise;
    frame(1'b1, 1'b0, -1, -1);
    repeat (4) idle_step();
    chk("blocked_frame_de", de_seen - de0, 32'd0);
    chk("blocked_frame_hsync", hs_rise - hs0, V);
    chk("frame_cnt_9", {16'd0, frame_cnt}, 32'd9);
    chk("line_err_final", {31'd0, line_err}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
